// File: rtl/am_tdm_if.sv
// Sample-frame bus for am_tdm: frame request, packed voice samples/envelopes and results.
interface am_tdm_if #(
    parameter int unsigned WAVE_W     = 12,
    parameter int unsigned ENV_W      = 8,
    parameter int unsigned NUM_VOICES = 3
);
    logic                           sample_start;
    logic [NUM_VOICES*WAVE_W-1:0]   wave_in;
    logic [NUM_VOICES*ENV_W-1:0]    env_in;
    logic [NUM_VOICES*WAVE_W-1:0]   wave_out;
    logic [WAVE_W-1:0]              mix_out;
    logic                           busy;
    logic                           done;

    modport master (
        output sample_start, wave_in, env_in,
        input  wave_out, mix_out, busy, done
    );

    modport slave (
        input  sample_start, wave_in, env_in,
        output wave_out, mix_out, busy, done
    );
endinterface

// File: rtl/am_tdm.sv
// Time-multiplexed AM scaler: one shared multiplier applies each voice envelope in turn
// and mixes the results with saturation. Define AM_TDM_ROUND_EN for round-half-up scaling.
module am_tdm #(
    parameter int unsigned WAVE_W     = 12,
    parameter int unsigned ENV_W      = 8,
    parameter int unsigned NUM_VOICES = 3
) (
    input  logic     clk,
    input  logic     rst_n,
    am_tdm_if.slave  bus
);
    localparam int unsigned IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned ACC_W  = WAVE_W + $clog2(NUM_VOICES) + 1;
    localparam int unsigned PROD_W = WAVE_W + ENV_W + 1;

    localparam logic signed [ACC_W-1:0]  ACC_MAX = ACC_W'((2 ** (WAVE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  ACC_MIN = ~ACC_MAX;
    localparam logic signed [WAVE_W-1:0] MIX_MAX = {1'b0, {(WAVE_W - 1){1'b1}}};
    localparam logic signed [WAVE_W-1:0] MIX_MIN = {1'b1, {(WAVE_W - 1){1'b0}}};
`ifdef AM_TDM_ROUND_EN
    localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) << (ENV_W - 1);
`endif

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [WAVE_W-1:0] wave_sh [NUM_VOICES];
    logic [ENV_W-1:0]         env_sh  [NUM_VOICES];
    logic signed [WAVE_W-1:0] wave_q  [NUM_VOICES];
    logic signed [WAVE_W-1:0] mix_q;
    logic                     busy_q;
    logic                     done_q;

    logic signed [PROD_W-1:0] wave_x_c;
    logic signed [PROD_W-1:0] env_x_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod_r_c;
    logic signed [WAVE_W-1:0] scaled_c;
    logic signed [WAVE_W-1:0] mix_sat_c;

    // Shared multiplier datapath, operating on the shadow copy of voice idx
    always_comb begin
        wave_x_c = PROD_W'(wave_sh[idx]);
        env_x_c  = PROD_W'($signed({1'b0, env_sh[idx]}));
        prod_c   = wave_x_c * env_x_c;
`ifdef AM_TDM_ROUND_EN
        prod_r_c = prod_c + RND;
`else
        prod_r_c = prod_c;
`endif
        scaled_c = WAVE_W'(prod_r_c >>> ENV_W);
    end

    // Clamp the wide accumulator into the output sample range
    always_comb begin
        mix_sat_c = WAVE_W'(acc);
        if (acc > ACC_MAX)
            mix_sat_c = MIX_MAX;
        else if (acc < ACC_MIN)
            mix_sat_c = MIX_MIN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            mix_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                wave_sh[v] <= '0;
                env_sh[v]  <= '0;
                wave_q[v]  <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample_start) begin
                        for (int v = 0; v < int'(NUM_VOICES); v++) begin
                            wave_sh[v] <= bus.wave_in[v*WAVE_W +: WAVE_W];
                            env_sh[v]  <= bus.env_in[v*ENV_W +: ENV_W];
                        end
                        acc    <= '0;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    wave_q[idx] <= scaled_c;
                    acc         <= acc + ACC_W'(scaled_c);
                    idx         <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_VOICES - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    mix_q  <= mix_sat_c;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    idx    <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar v = 0; v < int'(NUM_VOICES); v++) begin : g_pack
        assign bus.wave_out[v*WAVE_W +: WAVE_W] = wave_q[v];
    end

    assign bus.mix_out = mix_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_am_tdm.sv
// Directed self-checking bench for am_tdm at default parameters (12-bit waves, 8-bit envelopes, 3 voices).
module tb_am_tdm;
    localparam int unsigned WAVE_W = 12;
    localparam int unsigned ENV_W  = 8;
    localparam int unsigned NV     = 3;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    am_tdm_if #(.WAVE_W(WAVE_W), .ENV_W(ENV_W), .NUM_VOICES(NV)) bus ();

    am_tdm #(.WAVE_W(WAVE_W), .ENV_W(ENV_W), .NUM_VOICES(NV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wo(input int v);
        logic [WAVE_W-1:0] s;
        s = bus.wave_out[v*WAVE_W +: WAVE_W];
        return int'($signed(s));
    endfunction

    function automatic int mix();
        return int'($signed(bus.mix_out));
    endfunction

    task automatic set_voice(input int v, input int w, input int e);
        bus.wave_in[v*WAVE_W +: WAVE_W] = WAVE_W'(w);
        bus.env_in[v*ENV_W +: ENV_W]    = ENV_W'(e);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.sample_start = 1'b0;
        bus.wave_in = '0;
        bus.env_in  = '0;
        #12;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_mix", mix(), 0);
        check("rst_wave0", wo(0), 0);
        #10 rst_n = 1'b1;
        tick();

        // Single full-scale voice
        set_voice(0, 2047, 255); set_voice(1, 0, 0); set_voice(2, 0, 0);
        bus.sample_start = 1'b1;
        tick();                                    // edge k
        bus.sample_start = 1'b0;
        check("f1_busy_k", int'(bus.busy), 1);
        check("f1_done_k", int'(bus.done), 0);
        tick();                                    // k+1
        check("f1_wave0", wo(0), 2039);
        tick(); tick();                            // k+3
        check("f1_busy_k3", int'(bus.busy), 1);
        check("f1_done_k3", int'(bus.done), 0);
        tick();                                    // k+4
        check("f1_done", int'(bus.done), 1);
        check("f1_busy_end", int'(bus.busy), 0);
        check("f1_mix", mix(), 2039);
        tick();                                    // k+5
        check("f1_done_clr", int'(bus.done), 0);

        // Small-signal floor/round and half-scale envelope
        set_voice(0, -1, 1); set_voice(1, 100, 128); set_voice(2, 0, 0);
        bus.sample_start = 1'b1;
        tick();
        bus.sample_start = 1'b0;
        tick(); tick(); tick(); tick();
        check("f2_done", int'(bus.done), 1);
`ifdef AM_TDM_ROUND_EN
        check("f2_wave0", wo(0), 0);
        check("f2_mix", mix(), 50);
`else
        check("f2_wave0", wo(0), -1);
        check("f2_mix", mix(), 49);
`endif
        check("f2_wave1", wo(1), 50);

        // Positive saturation; inputs change and start pulses mid-frame
        for (int v = 0; v < int'(NV); v++) set_voice(v, 2047, 255);
        bus.sample_start = 1'b1;
        tick();                                    // edge k
        bus.sample_start = 1'b0;
        for (int v = 0; v < int'(NV); v++) set_voice(v, 0, 0);
        tick();                                    // k+1
        check("f3_wave0", wo(0), 2039);
        check("f3_wave1_old", wo(1), 50);
        bus.sample_start = 1'b1;
        tick();                                    // k+2, start ignored
        bus.sample_start = 1'b0;
        tick(); tick();                            // k+4
        check("f3_done", int'(bus.done), 1);
        check("f3_mix_sat", mix(), 2047);
        check("f3_wave2", wo(2), 2039);
        tick();
        check("f3_no_queue", int'(bus.busy), 0);
        tick();

        // Negative saturation, then start accepted in the done cycle
        for (int v = 0; v < int'(NV); v++) set_voice(v, -2048, 255);
        bus.sample_start = 1'b1;
        tick();
        bus.sample_start = 1'b0;
        tick(); tick(); tick(); tick();            // k+4
        check("f4_done", int'(bus.done), 1);
        check("f4_mix_sat", mix(), -2048);
        check("f4_wave1", wo(1), -2040);
        set_voice(0, 2047, 255); set_voice(1, 0, 0); set_voice(2, 0, 0);
        bus.sample_start = 1'b1;
        tick();                                    // k+5, accepted
        bus.sample_start = 1'b0;
        check("f5_busy", int'(bus.busy), 1);
        check("f5_done_clr", int'(bus.done), 0);
        tick(); tick(); tick();                    // k+8
        check("f5_done_early", int'(bus.done), 0);
        tick();                                    // k+9
        check("f5_done", int'(bus.done), 1);
        check("f5_mix", mix(), 2039);
        tick();

        // Reset in the middle of a frame
        for (int v = 0; v < int'(NV); v++) set_voice(v, 1000, 200);
        bus.sample_start = 1'b1;
        tick();                                    // k
        bus.sample_start = 1'b0;
        tick();                                    // k+1
        rst_n = 1'b0;
        #1;
        check("r_busy", int'(bus.busy), 0);
        check("r_mix", mix(), 0);
        check("r_wave0", wo(0), 0);
        tick(); tick(); tick();
        check("r_no_done", int'(bus.done), 0);
        #3 rst_n = 1'b1;
        tick();
        // 1000*200 = 200000; >>8 = 781 (781.25); 3 voices -> 2343 -> saturate 2047
        bus.sample_start = 1'b1;
        tick();
        bus.sample_start = 1'b0;
        tick(); tick(); tick();
        check("r2_done_early", int'(bus.done), 0);
        tick();
        check("r2_done", int'(bus.done), 1);
        check("r2_wave2", wo(2), 781);
        check("r2_mix", mix(), 2047);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
